// File: rtl/fifo_bit_reader.sv
// -----------------------------------------------------------------------------
// fifo_bit_reader
//
// Read-side consumer for a 1-bit-wide FIFO. It pulls single bits through the
// FIFO's empty/rd_en/dout port, packs WIDTH of them into a parallel word and
// offers that word downstream on a valid/ready handshake. This block is the
// only driver of the FIFO read enable.
//
// The FIFO registers its read data: a read accepted at edge N presents the bit
// on fifo_dout from edge N onward, so the bit is captured at edge N+1. Reads
// and captures therefore run one cycle apart. rd_pending marks the cycle in
// which a requested bit is in flight.
//
// Parameters
//   WIDTH      bits per assembled word (>= 2)
//   MSB_FIRST  1: first bit read lands in word_data[WIDTH-1]
//              0: first bit read lands in word_data[0]
//   CNT_W      width of the completed-word counter (wraps)
//
// Ports
//   clk          in   clock, all logic on posedge
//   rst_n        in   asynchronous active-low reset
//   fifo_empty   in   FIFO empty flag
//   fifo_dout    in   FIFO read data, valid from the edge after an accepted read
//   fifo_rd_en   out  FIFO read request (combinational)
//   flush        in   synchronous discard of any partial or pending word
//   word_data    out  assembled word, stable while word_valid is high
//   word_valid   out  word available
//   word_ready   in   sink accepts the word when word_valid & word_ready
//   word_count   out  number of words accepted by the sink, wraps to 0
// -----------------------------------------------------------------------------
module fifo_bit_reader #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fifo_empty,
    input  logic             fifo_dout,
    output logic             fifo_rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] word_data,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [CNT_W-1:0] word_count
);

    // Request and capture counters must be able to hold the value WIDTH.
    localparam int RC_W = $clog2(WIDTH + 1);
    localparam logic [RC_W-1:0] WIDTH_RC = RC_W'(WIDTH);
    localparam logic [RC_W-1:0] LAST_BIT = RC_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } state_t;

    state_t           state_q,      state_d;
    logic [RC_W-1:0]  req_cnt_q,    req_cnt_d;
    logic [RC_W-1:0]  bit_cnt_q,    bit_cnt_d;
    logic             rd_pending_q, rd_pending_d;
    logic [WIDTH-1:0] sr_q,         sr_d;
    logic [WIDTH-1:0] word_data_q,  word_data_d;
    logic             word_valid_q, word_valid_d;
    logic [CNT_W-1:0] word_count_q, word_count_d;

    logic             rd_accept;
    logic [WIDTH-1:0] sr_shifted;

    // Shift one bit into the partial word in the configured bit order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic             b);
        if (MSB_FIRST) begin
            return {sr[WIDTH-2:0], b};
        end else begin
            return {b, sr[WIDTH-1:1]};
        end
    endfunction

    // The read request is gated by rst_n so that no read is issued while the
    // block is held in reset, even though the reset state is COLLECT.
    // req_cnt caps reads at WIDTH per word so no bit of the next word is
    // pulled out of the FIFO before the current word has been handed off.
    always_comb begin
        rd_accept = rst_n
                    && (state_q == COLLECT)
                    && !fifo_empty
                    && (req_cnt_q < WIDTH_RC)
                    && !flush;
    end

    assign fifo_rd_en = rd_accept;

    // Next-state and datapath update.
    always_comb begin
        state_d      = state_q;
        req_cnt_d    = req_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        rd_pending_d = rd_accept;
        sr_d         = sr_q;
        word_data_d  = word_data_q;
        word_valid_d = word_valid_q;
        word_count_d = word_count_q;
        sr_shifted   = shift_in(sr_q, fifo_dout);

        if (flush) begin
            // Flush beats everything: partial bits, the in-flight bit and any
            // word waiting for the sink are all dropped without counting.
            state_d      = COLLECT;
            req_cnt_d    = '0;
            bit_cnt_d    = '0;
            sr_d         = '0;
            rd_pending_d = 1'b0;
            word_valid_d = 1'b0;
        end else begin
            case (state_q)
                COLLECT: begin
                    if (rd_accept) begin
                        req_cnt_d = req_cnt_q + 1'b1;
                    end
                    if (rd_pending_q) begin
                        if (bit_cnt_q == LAST_BIT) begin
                            // Last bit arrives: publish the finished word and
                            // start the next one from clean counters.
                            word_data_d  = sr_shifted;
                            word_valid_d = 1'b1;
                            state_d      = OUTPUT;
                            req_cnt_d    = '0;
                            bit_cnt_d    = '0;
                            sr_d         = '0;
                        end else begin
                            sr_d      = sr_shifted;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    // No reads are issued here, so rd_pending is already low
                    // and word_data stays frozen until the sink takes it.
                    if (word_valid_q && word_ready) begin
                        word_valid_d = 1'b0;
                        word_count_d = word_count_q + 1'b1;
                        state_d      = COLLECT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= COLLECT;
            req_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            rd_pending_q <= 1'b0;
            sr_q         <= '0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            req_cnt_q    <= req_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            rd_pending_q <= rd_pending_d;
            sr_q         <= sr_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            word_count_q <= word_count_d;
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_fifo_bit_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_bit_reader. Three instances share one bit FIFO model:
// MSB-first with a 16-bit counter, LSB-first, and MSB-first with a 2-bit
// counter. Read behaviour is identical across them, so the FIFO follows the
// first instance. Expected words are rebuilt from the log of popped bits, and
// a queue-based model of the word framing predicts the read enable, valid and
// count.
// -----------------------------------------------------------------------------
module tb_fifo_bit_reader;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         fifo_empty;
    logic         fifo_dout;
    logic         flush;
    logic         word_ready;

    logic         rd_m, rd_l, rd_c;
    logic [W-1:0] data_m, data_l, data_c;
    logic         vld_m, vld_l, vld_c;
    logic [15:0]  cnt_m, cnt_l;
    logic [1:0]   cnt_c;

    fifo_bit_reader #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(16)) u_msb (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_m), .flush(flush), .word_data(data_m), .word_valid(vld_m),
        .word_ready(word_ready), .word_count(cnt_m));

    fifo_bit_reader #(.WIDTH(W), .MSB_FIRST(1'b0), .CNT_W(16)) u_lsb (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_l), .flush(flush), .word_data(data_l), .word_valid(vld_l),
        .word_ready(word_ready), .word_count(cnt_l));

    fifo_bit_reader #(.WIDTH(W), .MSB_FIRST(1'b1), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(rd_c), .flush(flush), .word_data(data_c), .word_valid(vld_c),
        .word_ready(word_ready), .word_count(cnt_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks;
    int          failures;
    logic        fq[$];       // bits waiting in the FIFO
    logic        pop_log[$];  // every bit the FIFO has handed out, in order
    int          n_reads;
    int          rd_bad;      // cycles where any read enable disagreed with the model
    logic        obs_rd;      // read enable seen in the last stepped cycle

    // Word framing model: bits taken for the current word, word ready to go
    // out at the next edge, word presented to the sink, words accepted.
    logic        m_bits[$];
    logic        m_done;
    logic        m_valid;
    logic [15:0] m_count;

    task automatic model_clear();
        m_bits.delete();
        m_done  = 1'b0;
        m_valid = 1'b0;
        m_count = '0;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) begin
            fq.push_back(1'($urandom_range(0, 1)));
        end
        if (n > 0) fifo_empty = 1'b0;
    endtask

    function automatic logic [W-1:0] pack(input int start, input bit msb_first);
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            if (pop_log[start + i]) w = w | (W'(1) << (msb_first ? (W - 1 - i) : i));
        end
        return w;
    endfunction

    // One clock cycle: sample the read enable at the falling edge, let the
    // rising edge happen, then update the FIFO and the framing model.
    task automatic tick();
        logic exp_rd;
        logic b;
        @(negedge clk);
        exp_rd = rst_n && !m_valid && !fifo_empty && (m_bits.size() < W) && !flush;
        obs_rd = rd_m;
        if (rd_m !== exp_rd || rd_l !== exp_rd || rd_c !== exp_rd) rd_bad++;
        @(posedge clk);
        #1;
        b = 1'b0;
        if (obs_rd && !fifo_empty) begin
            b = fq.pop_front();
            fifo_dout = b;
            pop_log.push_back(b);
            n_reads++;
            fifo_empty = (fq.size() == 0);
        end
        if (!rst_n) begin
            model_clear();
        end else if (flush) begin
            m_bits.delete();
            m_done  = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (m_valid && word_ready) begin
                m_valid = 1'b0;
                m_count = m_count + 16'd1;
            end
            if (m_done) begin
                m_valid = 1'b1;
                m_done  = 1'b0;
                m_bits.delete();
            end
            if (exp_rd) begin
                m_bits.push_back(b);
                m_done = (m_bits.size() == W);
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (vld_m === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        rst_n = 1'b0; flush = 1'b0; word_ready = 1'b0;
        fifo_dout = 1'b0; fifo_empty = 1'b1;
        model_clear();
        for (int i = 0; i < 8; i++) fq.push_back(pat[7 - i]);
        fifo_empty = 1'b0;
        repeat (3) tick();
        checks++; if (rd_m !== 1'b0 || rd_l !== 1'b0 || rd_c !== 1'b0) begin failures++; $display("FAIL reset_rd_en: got %b%b%b expected 000", rd_m, rd_l, rd_c); end
        checks++; if (vld_m !== 1'b0 || vld_l !== 1'b0 || vld_c !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b%b%b expected 000", vld_m, vld_l, vld_c); end
        checks++; if (data_m !== 8'h00 || data_l !== 8'h00) begin failures++; $display("FAIL reset_data: got %h/%h expected 00", data_m, data_l); end
        checks++; if (cnt_m !== 16'd0 || cnt_c !== 2'd0) begin failures++; $display("FAIL reset_count: got %0d/%0d expected 0", cnt_m, cnt_c); end
        checks++; if (n_reads != 0) begin failures++; $display("FAIL reset_no_reads: got %0d expected 0", n_reads); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int first, last, vi, nrd;
        first = -1; last = -1; vi = -1; nrd = 0;
        word_ready = 1'b1;
        for (int i = 0; i < 30 && vi < 0; i++) begin
            tick();
            if (obs_rd) begin
                nrd++;
                if (first < 0) first = i;
                last = i;
            end
            if (vld_m === 1'b1) vi = i;
        end
        checks++; if (vi < 0) begin failures++; $display("FAIL basic_timeout: got no word_valid expected one within 30 cycles"); end
        checks++; if (nrd != 8) begin failures++; $display("FAIL basic_reads: got %0d expected 8", nrd); end
        checks++; if (last - first != 7) begin failures++; $display("FAIL basic_consecutive: got span %0d expected 7", last - first); end
        checks++; if (vi != last + 1) begin failures++; $display("FAIL basic_latency: got valid at %0d expected %0d", vi, last + 1); end
        checks++; if (data_m !== 8'hB2 || data_c !== 8'hB2) begin failures++; $display("FAIL basic_msb_word: got %h/%h expected b2", data_m, data_c); end
        checks++; if (data_l !== 8'h4D || vld_l !== 1'b1) begin failures++; $display("FAIL basic_lsb_word: got %h valid %b expected 4d valid 1", data_l, vld_l); end
        tick();
        checks++; if (vld_m !== 1'b0 || cnt_m !== 16'd1 || cnt_c !== 2'd1) begin failures++; $display("FAIL basic_handshake: got valid %b count %0d/%0d expected valid 0 count 1", vld_m, cnt_m, cnt_c); end
        checks++; if (rd_bad != 0) begin failures++; $display("FAIL basic_rd_trace: got %0d bad cycles expected 0", rd_bad); end
    endtask

    task automatic test_empty_stall();
        int base, r0, hi;
        bit ok;
        base = pop_log.size(); r0 = n_reads; hi = 0;
        word_ready = 1'b1;
        push_rand(3);
        for (int i = 0; i < 23; i++) begin
            tick();
            if (obs_rd) hi++;
        end
        checks++; if (hi != 3) begin failures++; $display("FAIL stall_rd_cycles: got %0d expected 3", hi); end
        checks++; if (vld_m !== 1'b0) begin failures++; $display("FAIL stall_valid: got %b expected 0", vld_m); end
        push_rand(5);
        wait_valid(30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: got no word_valid expected one after refill"); end
        checks++; if (n_reads - r0 != 8) begin failures++; $display("FAIL stall_reads: got %0d expected 8", n_reads - r0); end
        checks++; if (data_m !== pack(base, 1'b1) || data_l !== pack(base, 1'b0)) begin failures++; $display("FAIL stall_word: got %h/%h expected %h/%h", data_m, data_l, pack(base, 1'b1), pack(base, 1'b0)); end
        tick();
        checks++; if (vld_m !== 1'b0 || cnt_m !== m_count) begin failures++; $display("FAIL stall_count: got valid %b count %0d expected valid 0 count %0d", vld_m, cnt_m, m_count); end
        checks++; if (rd_bad != 0) begin failures++; $display("FAIL stall_rd_trace: got %0d bad cycles expected 0", rd_bad); end
    endtask

    task automatic test_backpressure();
        int base, hi, unstable;
        bit ok;
        logic [W-1:0] exp_w;
        base = pop_log.size(); hi = 0; unstable = 0;
        word_ready = 1'b0;
        push_rand(16);
        wait_valid(30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout: got no word_valid expected first word"); end
        exp_w = pack(base, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (obs_rd) hi++;
            if (data_m !== exp_w || vld_m !== 1'b1) unstable++;
        end
        checks++; if (unstable != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles expected 0 (word %h)", unstable, exp_w); end
        checks++; if (hi != 0) begin failures++; $display("FAIL bp_no_reads: got %0d read cycles expected 0", hi); end
        checks++; if (fq.size() != 8) begin failures++; $display("FAIL bp_fifo_level: got %0d expected 8", fq.size()); end
        word_ready = 1'b1;
        tick();
        checks++; if (obs_rd !== 1'b0 || vld_m !== 1'b0) begin failures++; $display("FAIL bp_release: got rd %b valid %b expected rd 0 valid 0", obs_rd, vld_m); end
        tick();
        checks++; if (obs_rd !== 1'b1) begin failures++; $display("FAIL bp_dead_cycle: got rd %b expected 1", obs_rd); end
        wait_valid(30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL bp_timeout2: got no word_valid expected second word"); end
        checks++; if (data_m !== pack(base + 8, 1'b1) || data_l !== pack(base + 8, 1'b0)) begin failures++; $display("FAIL bp_word2: got %h/%h expected %h/%h", data_m, data_l, pack(base + 8, 1'b1), pack(base + 8, 1'b0)); end
        tick();
        checks++; if (cnt_m !== m_count || rd_bad != 0) begin failures++; $display("FAIL bp_count: got count %0d bad %0d expected count %0d bad 0", cnt_m, rd_bad, m_count); end
    endtask

    task automatic test_flush();
        int base, r0;
        bit ok;
        logic [15:0] cnt0;
        base = pop_log.size(); r0 = n_reads; cnt0 = m_count;
        word_ready = 1'b1;
        push_rand(14);
        for (int i = 0; i < 20 && (n_reads - r0) < 6; i++) tick();
        checks++; if (n_reads - r0 != 6) begin failures++; $display("FAIL flush_setup: got %0d reads expected 6", n_reads - r0); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (obs_rd !== 1'b0 || vld_m !== 1'b0) begin failures++; $display("FAIL flush_rd_en: got rd %b valid %b expected 0 0", obs_rd, vld_m); end
        wait_valid(30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flush_timeout: got no word_valid expected fresh word"); end
        checks++; if (data_m !== pack(base + 6, 1'b1) || data_l !== pack(base + 6, 1'b0)) begin failures++; $display("FAIL flush_fresh_word: got %h/%h expected %h/%h", data_m, data_l, pack(base + 6, 1'b1), pack(base + 6, 1'b0)); end
        checks++; if (cnt_m !== cnt0) begin failures++; $display("FAIL flush_count_kept: got %0d expected %0d", cnt_m, cnt0); end
        tick();
        checks++; if (cnt_m !== cnt0 + 16'd1) begin failures++; $display("FAIL flush_count_next: got %0d expected %0d", cnt_m, cnt0 + 16'd1); end
        word_ready = 1'b0;
        push_rand(8);
        wait_valid(30, ok);
        checks++; if (!ok) begin failures++; $display("FAIL flush_out_timeout: got no word_valid expected word"); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (vld_m !== 1'b0 || vld_l !== 1'b0 || cnt_m !== cnt0 + 16'd1) begin failures++; $display("FAIL flush_output: got valid %b/%b count %0d expected 0/0 count %0d", vld_m, vld_l, cnt_m, cnt0 + 16'd1); end
        word_ready = 1'b1;
        repeat (3) tick();
        checks++; if (vld_m !== 1'b0 || rd_bad != 0) begin failures++; $display("FAIL flush_after: got valid %b bad %0d expected valid 0 bad 0", vld_m, rd_bad); end
    endtask

    task automatic test_async_reset_wrap();
        int base, r0;
        bit ok;
        r0 = n_reads;
        word_ready = 1'b1;
        push_rand(8);
        for (int i = 0; i < 20 && (n_reads - r0) < 4; i++) tick();
        checks++; if (cnt_m !== m_count) begin failures++; $display("FAIL rst_pre_count: got %0d expected %0d", cnt_m, m_count); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (vld_m !== 1'b0 || cnt_m !== 16'd0 || cnt_c !== 2'd0 || data_m !== 8'h00) begin failures++; $display("FAIL rst_async: got valid %b count %0d/%0d data %h expected 0 0/0 00", vld_m, cnt_m, cnt_c, data_m); end
        checks++; if (rd_m !== 1'b0) begin failures++; $display("FAIL rst_async_rd: got %b expected 0", rd_m); end
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_rand(36);
        base = pop_log.size();
        for (int w = 1; w <= 5; w++) begin
            wait_valid(40, ok);
            checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout: got no word_valid expected word %0d", w); end
            checks++; if (data_m !== pack(base + 8 * (w - 1), 1'b1)) begin failures++; $display("FAIL wrap_word: got %h expected %h", data_m, pack(base + 8 * (w - 1), 1'b1)); end
            tick();
            checks++; if (cnt_c !== 2'(w % 4) || cnt_m !== 16'(w)) begin failures++; $display("FAIL wrap_count: got %0d/%0d expected %0d/%0d", cnt_c, cnt_m, w % 4, w); end
        end
        checks++; if (rd_bad != 0) begin failures++; $display("FAIL wrap_rd_trace: got %0d bad cycles expected 0", rd_bad); end
    endtask

    initial begin
        checks = 0; failures = 0; n_reads = 0; rd_bad = 0; obs_rd = 1'b0;
        test_reset();
        test_basic();
        test_empty_stall();
        test_backpressure();
        test_flush();
        test_async_reset_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
